// File: rtl/accum_warp_looper_stencil_multi_if.sv
// Warp-in / multi-lane-beat-out bus of the accumulation warp looper stencil stage.
interface accum_warp_looper_stencil_multi_if #(
    parameter int N_CFG  = 4,
    parameter int ABW    = 16,
    parameter int WBW    = 8,
    parameter int VDIM   = 2,
    parameter int STSIZE = 8,
    parameter int NLANE  = 2
);
    localparam int NCFG_BW = $clog2(N_CFG + 1);
    localparam int ST_BW   = $clog2(STSIZE + 1);

    logic                           src_rdy;
    logic                           src_ack;
    logic [NCFG_BW-1:0]             i_id;
    logic [ABW-1:0]                 i_linear;
    logic [VDIM-1:0][WBW-1:0]       i_bofs;
    logic                           i_retire;
    logic                           i_islast;
    logic                           i_stencil;

    logic                           dst_rdy;
    logic                           dst_ack;
    logic [NCFG_BW-1:0]             o_id;
    logic [VDIM-1:0][WBW-1:0]       o_bofs;
    logic [NLANE-1:0][ABW-1:0]      o_linear;
    logic [NLANE-1:0]               o_lane_valid;
    logic [ST_BW-1:0]               o_sidx;
    logic                           o_retire;
    logic                           o_islast;

    modport master (
        output src_rdy, i_id, i_linear, i_bofs, i_retire, i_islast, i_stencil, dst_ack,
        input  src_ack, dst_rdy, o_id, o_bofs, o_linear, o_lane_valid, o_sidx, o_retire, o_islast
    );

    modport slave (
        input  src_rdy, i_id, i_linear, i_bofs, i_retire, i_islast, i_stencil, dst_ack,
        output src_ack, dst_rdy, o_id, o_bofs, o_linear, o_lane_valid, o_sidx, o_retire, o_islast
    );
endinterface

// File: rtl/accum_warp_looper_stencil_multi.sv
// Expands each accepted warp into ceil(range/NLANE) beats of NLANE stencil-offset addresses;
// the final beat carries retire/islast and can overlap acceptance of the next warp.
module accum_warp_looper_stencil_multi #(
    parameter int N_CFG  = 4,
    parameter int ABW    = 16,
    parameter int STSIZE = 8,
    parameter int NLANE  = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    accum_warp_looper_stencil_multi_if.slave  bus,
    input  logic [N_CFG-1:0][$clog2(STSIZE+1)-1:0] i_stencil_begs,
    input  logic [N_CFG-1:0][$clog2(STSIZE+1)-1:0] i_stencil_ends,
    input  logic [STSIZE-1:0][ABW-1:0]        i_stencil_lut
);
    localparam int WBW     = 8;
    localparam int VDIM    = 2;
    localparam int NCFG_BW = $clog2(N_CFG + 1);
    localparam int ST_BW   = $clog2(STSIZE + 1);

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t                   state_r, state_nx;
    logic [ST_BW-1:0]         cursor_r, end_r;
    logic                     st_r, empty_rng_r, retire_r, islast_r;
    logic [NCFG_BW-1:0]       id_r;
    logic [ABW-1:0]           linear_r;
    logic [VDIM-1:0][WBW-1:0] bofs_r;

    logic [ST_BW-1:0]         beg_sel, end_sel;
    logic                     final_beat;
    logic                     src_ack;
    logic                     full;

    // Config lookup by compare-select so an out-of-range id reads as an empty range.
    always_comb begin
        beg_sel = '0;
        end_sel = '0;
        for (int unsigned c = 0; c < N_CFG; c++) begin
            if (bus.i_id == NCFG_BW'(c)) begin
                beg_sel = i_stencil_begs[c];
                end_sel = i_stencil_ends[c];
            end
        end
    end

    always_comb begin
        final_beat = !st_r || empty_rng_r ||
                     (({1'b0, cursor_r} + (ST_BW+1)'(NLANE)) >= {1'b0, end_r});
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_r <= EMPTY;
        else       state_r <= state_nx;
    end

    always_comb begin
        state_nx = state_r;
        case (state_r)
            EMPTY: if (src_ack) state_nx = HOLD;
            HOLD:  if (!src_ack && bus.dst_ack && final_beat) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    always_comb begin
        full        = (state_r == HOLD);
        bus.dst_rdy = full;
        src_ack     = bus.src_rdy && !i_rst && (!full || (bus.dst_ack && final_beat));
        bus.src_ack = src_ack;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cursor_r    <= '0;
            end_r       <= '0;
            st_r        <= 1'b0;
            empty_rng_r <= 1'b0;
            retire_r    <= 1'b0;
            islast_r    <= 1'b0;
            id_r        <= '0;
            linear_r    <= '0;
            bofs_r      <= '0;
        end else if (src_ack) begin
            cursor_r    <= beg_sel;
            end_r       <= end_sel;
            st_r        <= bus.i_stencil;
            empty_rng_r <= (beg_sel >= end_sel);
            retire_r    <= bus.i_retire;
            islast_r    <= bus.i_islast;
            id_r        <= bus.i_id;
            linear_r    <= bus.i_linear;
            bofs_r      <= bus.i_bofs;
        end else if (full && bus.dst_ack && !final_beat) begin
            cursor_r    <= cursor_r + ST_BW'(NLANE);
        end
    end

    // Invalid lanes read as zero and never index the LUT.
    always_comb begin
        logic [ST_BW:0]  sid;
        logic [ABW-1:0]  lut_val;
        bus.o_linear     = '0;
        bus.o_lane_valid = '0;
        sid              = '0;
        lut_val          = '0;
        for (int unsigned k = 0; k < NLANE; k++) begin
            sid     = {1'b0, cursor_r} + (ST_BW+1)'(k);
            lut_val = '0;
            if (full) begin
                if (st_r) begin
                    if (sid < {1'b0, end_r}) begin
                        for (int unsigned j = 0; j < STSIZE; j++) begin
                            if (sid == (ST_BW+1)'(j)) lut_val = i_stencil_lut[j];
                        end
                        bus.o_lane_valid[k] = 1'b1;
                        bus.o_linear[k]     = linear_r + lut_val;
                    end
                end else if (k == 0) begin
                    bus.o_lane_valid[k] = 1'b1;
                    bus.o_linear[k]     = linear_r;
                end
            end
        end
    end

    always_comb begin
        bus.o_id     = id_r;
        bus.o_bofs   = bofs_r;
        bus.o_sidx   = st_r ? cursor_r : '0;
        bus.o_retire = full && retire_r && final_beat;
        bus.o_islast = full && islast_r && final_beat;
    end
endmodule

// File: tb/tb_accum_warp_looper_stencil_multi.sv
// Directed-vector bench for the multi-lane stencil looper: each task drives a scenario and
// checks packed beat outputs against hand-computed values.
module tb_accum_warp_looper_stencil_multi;
    localparam int N_CFG  = 4;
    localparam int ABW    = 16;
    localparam int WBW    = 8;
    localparam int VDIM   = 2;
    localparam int STSIZE = 8;
    localparam int NLANE  = 2;
    localparam int ST_BW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N_CFG-1:0][ST_BW-1:0] begs, ends;
    logic [STSIZE-1:0][ABW-1:0]  lut;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    accum_warp_looper_stencil_multi_if #(
        .N_CFG(N_CFG), .ABW(ABW), .WBW(WBW), .VDIM(VDIM), .STSIZE(STSIZE), .NLANE(NLANE)
    ) bus ();

    accum_warp_looper_stencil_multi #(
        .N_CFG(N_CFG), .ABW(ABW), .STSIZE(STSIZE), .NLANE(NLANE)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .bus            (bus),
        .i_stencil_begs (begs),
        .i_stencil_ends (ends),
        .i_stencil_lut  (lut)
    );

    // Packed view: {dst_rdy, valid[1:0], lane1, lane0, sidx, retire, islast}
    function automatic logic [40:0] beat(input logic rdy, input logic [1:0] v,
                                         input logic [15:0] l1, input logic [15:0] l0,
                                         input logic [3:0] sidx, input logic ret, input logic last);
        return {rdy, v, l1, l0, sidx, ret, last};
    endfunction

    function automatic logic [40:0] obs();
        return {bus.dst_rdy, bus.o_lane_valid, bus.o_linear[1], bus.o_linear[0],
                bus.o_sidx, bus.o_retire, bus.o_islast};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_warp(input logic [2:0] id, input logic [15:0] linear, input logic st,
                            input logic ret, input logic last);
        bus.i_id      = id;
        bus.i_linear  = linear;
        bus.i_stencil = st;
        bus.i_retire  = ret;
        bus.i_islast  = last;
        bus.i_bofs    = {8'hA5, 8'h3C};
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.src_rdy = 1'b1;
        bus.dst_ack = 1'b1;
        set_warp(3'd1, 16'd100, 1'b1, 1'b1, 1'b1);
        next_cycle();
        next_cycle();
        #1;
        chk_cnt++;
        if (obs() !== beat(0, 2'b00, 0, 0, 0, 0, 0))
            $display("FAIL reset_outputs got %h exp %h", obs(), beat(0, 2'b00, 0, 0, 0, 0, 0));
        else pass_cnt++;
        chk_cnt++;
        if (bus.src_ack !== 1'b0) $display("FAIL reset_src_ack got %b exp 0", bus.src_ack);
        else pass_cnt++;
        bus.src_rdy = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_stencil_multi();
        set_warp(3'd1, 16'd100, 1'b1, 1'b0, 1'b1);
        bus.src_rdy = 1'b1;
        bus.dst_ack = 1'b1;
        #1;
        chk_cnt++;
        if (bus.src_ack !== 1'b1) $display("FAIL multi_accept got %b exp 1", bus.src_ack);
        else pass_cnt++;
        next_cycle();
        bus.src_rdy = 1'b0;
        #1;
        chk_cnt++;
        if (obs() !== beat(1, 2'b11, 130, 120, 2, 0, 0))
            $display("FAIL multi_beat1 got %h exp %h", obs(), beat(1, 2'b11, 130, 120, 2, 0, 0));
        else pass_cnt++;
        chk_cnt++;
        if (bus.o_id !== 3'd1 || bus.o_bofs !== {8'hA5, 8'h3C})
            $display("FAIL multi_fields got %h/%h exp 1/a53c", bus.o_id, bus.o_bofs);
        else pass_cnt++;
        next_cycle();
        chk_cnt++;
        if (obs() !== beat(1, 2'b11, 150, 140, 4, 0, 0))
            $display("FAIL multi_beat2 got %h exp %h", obs(), beat(1, 2'b11, 150, 140, 4, 0, 0));
        else pass_cnt++;
        next_cycle();
        chk_cnt++;
        if (obs() !== beat(1, 2'b01, 0, 160, 6, 0, 1))
            $display("FAIL multi_beat3 got %h exp %h", obs(), beat(1, 2'b01, 0, 160, 6, 0, 1));
        else pass_cnt++;
        next_cycle();
        chk_cnt++;
        if (bus.dst_rdy !== 1'b0) $display("FAIL multi_drain got %b exp 0", bus.dst_rdy);
        else pass_cnt++;
    endtask

    task automatic test_non_stencil();
        set_warp(3'd0, 16'd55, 1'b0, 1'b1, 1'b0);
        bus.src_rdy = 1'b1;
        bus.dst_ack = 1'b1;
        next_cycle();
        bus.src_rdy = 1'b0;
        #1;
        chk_cnt++;
        if (obs() !== beat(1, 2'b01, 0, 55, 0, 1, 0))
            $display("FAIL nonst_beat got %h exp %h", obs(), beat(1, 2'b01, 0, 55, 0, 1, 0));
        else pass_cnt++;
        next_cycle();
        chk_cnt++;
        if (bus.dst_rdy !== 1'b0) $display("FAIL nonst_drain got %b exp 0", bus.dst_rdy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        set_warp(3'd0, 16'd1000, 1'b1, 1'b1, 1'b0);
        bus.src_rdy = 1'b1;
        bus.dst_ack = 1'b1;
        next_cycle();
        set_warp(3'd1, 16'd77, 1'b0, 1'b0, 1'b1);
        #1;
        chk_cnt++;
        if (obs() !== beat(1, 2'b11, 1010, 1002, 0, 0, 0) || bus.src_ack !== 1'b0)
            $display("FAIL b2b_a1 got %h ack %b exp %h ack 0", obs(), bus.src_ack,
                     beat(1, 2'b11, 1010, 1002, 0, 0, 0));
        else pass_cnt++;
        next_cycle();
        chk_cnt++;
        if (obs() !== beat(1, 2'b01, 0, 1020, 2, 1, 0) || bus.src_ack !== 1'b1)
            $display("FAIL b2b_a2 got %h ack %b exp %h ack 1", obs(), bus.src_ack,
                     beat(1, 2'b01, 0, 1020, 2, 1, 0));
        else pass_cnt++;
        next_cycle();
        bus.src_rdy = 1'b0;
        #1;
        chk_cnt++;
        if (obs() !== beat(1, 2'b01, 0, 77, 0, 0, 1))
            $display("FAIL b2b_b got %h exp %h", obs(), beat(1, 2'b01, 0, 77, 0, 0, 1));
        else pass_cnt++;
        next_cycle();
        chk_cnt++;
        if (bus.dst_rdy !== 1'b0) $display("FAIL b2b_drain got %b exp 0", bus.dst_rdy);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        set_warp(3'd1, 16'd100, 1'b1, 1'b0, 1'b1);
        bus.src_rdy = 1'b1;
        bus.dst_ack = 1'b0;
        next_cycle();
        bus.dst_ack = 1'b1;
        #1;
        chk_cnt++;
        if (obs() !== beat(1, 2'b11, 130, 120, 2, 0, 0) || bus.src_ack !== 1'b0)
            $display("FAIL stall_beat1 got %h ack %b exp %h ack 0", obs(), bus.src_ack,
                     beat(1, 2'b11, 130, 120, 2, 0, 0));
        else pass_cnt++;
        next_cycle();
        bus.dst_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_cnt++;
            if (obs() !== beat(1, 2'b11, 150, 140, 4, 0, 0) || bus.src_ack !== 1'b0)
                $display("FAIL stall_hold%0d got %h ack %b exp %h ack 0", i, obs(), bus.src_ack,
                         beat(1, 2'b11, 150, 140, 4, 0, 0));
            else pass_cnt++;
            next_cycle();
        end
        bus.src_rdy = 1'b0;
        bus.dst_ack = 1'b1;
        #1;
        chk_cnt++;
        if (obs() !== beat(1, 2'b11, 150, 140, 4, 0, 0))
            $display("FAIL stall_resume got %h exp %h", obs(), beat(1, 2'b11, 150, 140, 4, 0, 0));
        else pass_cnt++;
        next_cycle();
        chk_cnt++;
        if (obs() !== beat(1, 2'b01, 0, 160, 6, 0, 1))
            $display("FAIL stall_final got %h exp %h", obs(), beat(1, 2'b01, 0, 160, 6, 0, 1));
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_empty_range();
        set_warp(3'd2, 16'd500, 1'b1, 1'b1, 1'b1);
        bus.src_rdy = 1'b1;
        bus.dst_ack = 1'b1;
        next_cycle();
        bus.src_rdy = 1'b0;
        #1;
        chk_cnt++;
        if (obs() !== beat(1, 2'b00, 0, 0, 4, 1, 1))
            $display("FAIL empty_beat got %h exp %h", obs(), beat(1, 2'b00, 0, 0, 4, 1, 1));
        else pass_cnt++;
        next_cycle();
        chk_cnt++;
        if (bus.dst_rdy !== 1'b0) $display("FAIL empty_drain got %b exp 0", bus.dst_rdy);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        set_warp(3'd3, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        bus.src_rdy = 1'b1;
        bus.dst_ack = 1'b1;
        next_cycle();
        bus.src_rdy = 1'b0;
        #1;
        chk_cnt++;
        if (obs() !== beat(1, 2'b01, 0, 1, 0, 0, 0))
            $display("FAIL wrap_beat got %h exp %h", obs(), beat(1, 2'b01, 0, 1, 0, 0, 0));
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        set_warp(3'd1, 16'd100, 1'b1, 1'b1, 1'b1);
        bus.src_rdy = 1'b1;
        bus.dst_ack = 1'b1;
        next_cycle();
        bus.src_rdy = 1'b0;
        next_cycle();
        #1;
        chk_cnt++;
        if (obs() !== beat(1, 2'b11, 150, 140, 4, 0, 0))
            $display("FAIL rstmid_beat2 got %h exp %h", obs(), beat(1, 2'b11, 150, 140, 4, 0, 0));
        else pass_cnt++;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        chk_cnt++;
        if (obs() !== beat(0, 2'b00, 0, 0, 0, 0, 0) || bus.o_id !== 3'd0)
            $display("FAIL rstmid_clear got %h exp %h", obs(), beat(0, 2'b00, 0, 0, 0, 0, 0));
        else pass_cnt++;
        bus.src_rdy = 1'b1;
        next_cycle();
        bus.src_rdy = 1'b0;
        #1;
        chk_cnt++;
        if (obs() !== beat(1, 2'b11, 130, 120, 2, 0, 0))
            $display("FAIL rstmid_restart got %h exp %h", obs(), beat(1, 2'b11, 130, 120, 2, 0, 0));
        else pass_cnt++;
        next_cycle();
        next_cycle();
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < STSIZE; i++) lut[i] = 16'(10 * i);
        lut[0] = 16'd2;
        begs = '0;
        ends = '0;
        begs[0] = 4'd0; ends[0] = 4'd3;
        begs[1] = 4'd2; ends[1] = 4'd7;
        begs[2] = 4'd4; ends[2] = 4'd4;
        begs[3] = 4'd0; ends[3] = 4'd1;
        bus.src_rdy = 1'b0;
        bus.dst_ack = 1'b0;
        set_warp(3'd0, 16'd0, 1'b0, 1'b0, 1'b0);

        test_reset();
        test_stencil_multi();
        test_non_stencil();
        test_back_to_back();
        test_stall();
        test_empty_range();
        test_wrap();
        test_reset_mid();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/accum_warp_looper_stencil_multi.md
# accum_warp_looper_stencil_multi

Multi-lane stencil expansion stage for the accumulation warp looper. It sits between the warp address generator and the accumulation datapath. For each accepted warp it walks that config's stencil index range [begs[id], ends[id]) and emits NLANE stencil-offset addresses per output beat instead of one. Retire/last flags are forwarded only on the final beat, and a new warp can be accepted in the same cycle the final beat drains, so there is no bubble between warps.

## Interface
Parameters:
- N_CFG, TauCfg::N_ICFG, number of configs; NCFG_BW = $clog2(N_CFG+1)
- ABW, TauCfg::GLOBAL_ADDR_BW, address width
- WBW, TauCfg::WORK_BW, block-offset width (localparam)
- VDIM, TauCfg::VDIM, offset vector length (localparam)
- STSIZE, TauCfg::STENCIL_SIZE, LUT depth; ST_BW = $clog2(STSIZE+1)
- NLANE, 2, stencil addresses emitted per beat (1..STSIZE)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset: synchronous, active-high
- src_rdy  in  1  upstream warp valid
- src_ack  out  1  upstream warp accepted
- i_id  in  NCFG_BW  config id
- i_linear  in  ABW  base address
- i_bofs  in  WBW x VDIM  block offsets
- i_retire, i_islast  in  1 each  warp flags
- i_stencil  in  1  stencil enable, sampled at src_ack
- i_stencil_begs, i_stencil_ends  in  ST_BW x N_CFG  per-config index range; quasi-static
- i_stencil_lut  in  ABW x STSIZE  offset LUT; quasi-static
- dst_rdy  out  1  output beat valid
- dst_ack  in  1  output beat consumed
- o_id, o_bofs  out  NCFG_BW / WBW x VDIM  held warp fields
- o_linear  out  ABW x NLANE  lane addresses
- o_lane_valid  out  NLANE  lane mask
- o_sidx  out  ST_BW  stencil index of lane 0
- o_retire, o_islast  out  1 each  asserted only on the final beat

## Operation
- Handshake: a transfer occurs on the cycle ack=1. ack is asserted only while the matching rdy=1.
- State: full_r (0 = EMPTY, 1 = HOLD), cursor_r, end_r, st_r, plus registered warp fields.
- Derived signals:
  - empty_rng = (begs[id] >= ends[id]).
  - final = !st_r || empty_rng_r || cursor_r + NLANE >= end_r. Compute at ST_BW+1 bits so the sum cannot overflow.
- src_ack = src_rdy && (!full_r || (dst_ack && final)).
- On src_ack:
  - Capture id, linear, bofs, retire, islast, st_r = i_stencil.
  - Load cursor_r = begs[i_id] and end_r = ends[i_id].
  - Set full_r = 1.
- On dst_ack && !final: cursor_r += NLANE, fields held.
- On dst_ack && final && !src_ack: full_r = 0.
- Lane k output:
  - sid = cursor_r + k.
  - If st_r, valid_k = sid < end_r and o_linear[k] = linear_r + lut[sid], added mod 2^ABW. When valid_k = 0, drive o_linear[k] = 0 and do not index the LUT.
  - If !st_r, lane 0 is valid with o_linear[0] = linear_r; other lanes are invalid and 0.
- Empty range with st_r=1: one beat, o_lane_valid = 0, flags forwarded.
- o_retire = retire_r && final; o_islast = islast_r && final.
- o_sidx = st_r ? cursor_r : 0.
- dst_rdy = full_r.
- Outputs are combinational from registers only; there is no src→dst combinational path except src_ack depending on dst_ack.

## Timing
- Latency: src_ack in cycle t makes dst_rdy=1 at t+1.
- Throughput: one beat per cycle. A warp takes ceil((end-beg)/NLANE) beats; non-stencil and empty-range warps take 1 beat.
- Back-to-back: dst_ack on the final beat together with src_rdy gives src_ack the same cycle, and the next warp's first beat appears at t+1 with no gap.
- dst_rdy stalls (dst_ack=0) hold all outputs stable.
- Reset values: full_r=0, cursor_r=0, end_r=0, st_r=0, all fields 0.
  - Hence dst_rdy=0, o_lane_valid=0, o_linear=0, o_retire=o_islast=0, o_sidx=0.
  - src_ack=0 while i_rst=1.
- Reset mid-warp discards the held warp; the first cycle after reset is EMPTY.
- LUT and begs/ends changing while full_r=1 is illegal. i_stencil may toggle freely because it is sampled.

## Test plan
- NLANE=2, cfg1 beg=2 end=7, lut[i]=10*i, linear=100, islast=1, dst_ack tied high → beats:
  - (120,130) valid 11, sidx 2
  - (140,150) valid 11, sidx 4
  - (160,0) valid 01, sidx 6, o_islast=1 only on this beat
- i_stencil=0, linear=55, retire=1 → single beat at t+1: o_linear[0]=55, valid 01, o_retire=1.
- Two warps back-to-back, src_rdy continuous → second warp's src_ack coincides with the first warp's final dst_ack; no idle cycle on dst_rdy.
- dst_ack=0 for 3 cycles mid-warp → outputs and o_sidx frozen; src_ack stays 0.
- beg=end=4 with stencil → one beat, valid 00, flags forwarded; linear=0xFFF..F + lut=2 wraps to 1.
- Assert i_rst during the second beat → next cycle dst_rdy=0 and all outputs 0; a fresh warp then restarts from beg.
